// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, halt encoding, opcode field values
// and the fetch-stage state encoding.
package cpu_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 8;

    // Word that fills unused ROM; fetching it stops the front end.
    localparam logic [WORD_W-1:0] HALT_WORD = 16'h0000;

    // Opcode field [15:12] values.
    localparam logic [3:0] OP_ALU  = 4'hF;  // ADD/SUB group
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_ANDI = 4'h6;
    localparam logic [3:0] OP_LB   = 4'h2;
    localparam logic [3:0] OP_SB   = 4'h4;
    localparam logic [3:0] OP_BNE  = 4'h9;
    localparam logic [3:0] OP_BLTZ = 4'hB;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HALT  = 2'd2
    } fetch_state_e;

    // Instructions are two bytes; the PC wraps modulo 256.
    function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
        return pc + 8'd2;
    endfunction

endpackage

// File: rtl/ifetch.sv
// Instruction fetch stage: PC, ROM addressing, instruction register with a
// valid/ready handoff to decode, branch redirect and halt-word detection.
module ifetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 8'h00,
    parameter logic [WORD_W-1:0] HALT_WORD = cpu_pkg::HALT_WORD
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [ADDR_W-1:0] ADDR,
    input  logic [WORD_W-1:0] Q,
    output logic [WORD_W-1:0] IR,
    output logic [ADDR_W-1:0] IR_PC,
    output logic              IR_VALID,
    input  logic              DEC_READY,
    input  logic              REDIRECT,
    input  logic [ADDR_W-1:0] REDIRECT_PC,
    output logic              HALTED,
    output logic [WORD_W-1:0] ICOUNT
);

    localparam logic [ADDR_W-1:0] PC_INIT = RESET_PC & 8'hFE;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              ir_valid_q, ir_valid_d;
    logic [WORD_W-1:0] icount_q, icount_d;

    logic transfer;
    logic load_ok;

    assign transfer = ir_valid_q & DEC_READY;
    assign load_ok  = ~ir_valid_q | DEC_READY;

    // Next-state: redirect overrides everything; otherwise the FSM decides
    // whether the ROM word is captured, and the delivery counter runs alongside.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        icount_d   = icount_q;

        if (transfer && (icount_q != 16'hFFFF)) begin
            icount_d = icount_q + 16'd1;
        end

        if (transfer) begin
            ir_valid_d = 1'b0;
        end

        if (REDIRECT) begin
            // Masking instead of slicing keeps the odd target bit explicitly dropped.
            pc_d       = REDIRECT_PC & 8'hFE;
            ir_valid_d = 1'b0;
            state_d    = FS_FETCH;
        end else begin
            unique case (state_q)
                FS_BOOT: begin
                    state_d = FS_FETCH;
                end
                FS_FETCH: begin
                    if (load_ok) begin
                        if (Q != HALT_WORD) begin
                            ir_d       = Q;
                            ir_pc_d    = pc_q;
                            ir_valid_d = 1'b1;
                            pc_d       = pc_next(pc_q);
                        end else begin
                            ir_valid_d = 1'b0;
                            state_d    = FS_HALT;
                        end
                    end
                end
                FS_HALT: begin
                    ir_valid_d = 1'b0;
                end
                default: begin
                    state_d = FS_BOOT;
                end
            endcase
        end
    end

    // All fetch state in one register bank with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= FS_BOOT;
            pc_q       <= PC_INIT;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            icount_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            icount_q   <= icount_d;
        end
    end

    assign ADDR     = pc_q;
    assign IR       = ir_q;
    assign IR_PC    = ir_pc_q;
    assign IR_VALID = ir_valid_q;
    assign HALTED   = (state_q == FS_HALT);
    assign ICOUNT   = icount_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a behavioural 128x16 ROM.
`timescale 1ns/1ps
module tb_ifetch;

    logic        clk;
    logic        rst_n;
    logic [7:0]  addr;
    logic [15:0] q;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        dec_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        halted;
    logic [15:0] icount;

    logic [15:0] rom [128];

    int n_tests;
    int n_fail;

    // Observed/expected bundle: {IR_VALID, HALTED, IR_PC, ADDR, ICOUNT}
    logic [33:0] obs;
    logic [33:0] exp_v;

    ifetch #(
        .RESET_PC (8'h01),
        .HALT_WORD(16'h0000)
    ) dut (
        .CLK        (clk),
        .RESET      (rst_n),
        .ADDR       (addr),
        .Q          (q),
        .IR         (ir),
        .IR_PC      (ir_pc),
        .IR_VALID   (ir_valid),
        .DEC_READY  (dec_ready),
        .REDIRECT   (redirect),
        .REDIRECT_PC(redirect_pc),
        .HALTED     (halted),
        .ICOUNT     (icount)
    );

    assign q   = rom[addr[7:1]];
    assign obs = {ir_valid, halted, ir_pc, addr, icount};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        step();
        n_tests++;
        exp_v = {1'b0, 1'b0, 8'h00, 8'h00, 16'd0};
        if (obs !== exp_v) begin
            $display("FAIL reset_state: got %h expected %h", obs, exp_v);
            n_fail++;
        end
        n_tests++;
        if (ir !== 16'h0000) begin
            $display("FAIL reset_ir: got %h expected 0000", ir);
            n_fail++;
        end
    endtask

    task automatic test_startup();
        dec_ready = 1'b1;
        rst_n     = 1'b1;
        step();
        n_tests++;
        exp_v = {1'b0, 1'b0, 8'h00, 8'h00, 16'd0};
        if (obs !== exp_v) begin
            $display("FAIL boot_cycle: got %h expected %h", obs, exp_v);
            n_fail++;
        end
        for (int k = 0; k < 5; k++) begin
            step();
            n_tests++;
            exp_v = {1'b1, 1'b0, 8'(2*k), 8'(2*k+2), 16'(k)};
            if (obs !== exp_v) begin
                $display("FAIL startup_seq%0d: got %h expected %h", k, obs, exp_v);
                n_fail++;
            end
        end
        n_tests++;
        if (ir !== 16'hF005) begin
            $display("FAIL startup_ir: got %h expected F005", ir);
            n_fail++;
        end
    endtask

    task automatic test_backpressure();
        // IR_PC=08 valid, ADDR=0A, ICOUNT=4
        dec_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            exp_v = {1'b1, 1'b0, 8'h08, 8'h0A, 16'd4};
            if (obs !== exp_v || ir !== 16'hF005) begin
                $display("FAIL stall%0d: got %h/%h expected %h/F005", k, obs, ir, exp_v);
                n_fail++;
            end
        end
        dec_ready = 1'b1;
        step();
        n_tests++;
        exp_v = {1'b1, 1'b0, 8'h0A, 8'h0C, 16'd5};
        if (obs !== exp_v || ir !== 16'hF006) begin
            $display("FAIL stall_resume: got %h/%h expected %h/F006", obs, ir, exp_v);
            n_fail++;
        end
        step();
        n_tests++;
        exp_v = {1'b1, 1'b0, 8'h0C, 8'h0E, 16'd6};
        if (obs !== exp_v) begin
            $display("FAIL stall_resume2: got %h expected %h", obs, exp_v);
            n_fail++;
        end
    endtask

    task automatic test_redirect();
        repeat (9) step();
        n_tests++;
        exp_v = {1'b1, 1'b0, 8'h1E, 8'h20, 16'd15};
        if (obs !== exp_v) begin
            $display("FAIL pre_redirect: got %h expected %h", obs, exp_v);
            n_fail++;
        end
        redirect    = 1'b1;
        redirect_pc = 8'h11;
        step();
        redirect = 1'b0;
        n_tests++;
        exp_v = {1'b0, 1'b0, 8'h1E, 8'h10, 16'd16};
        if (obs !== exp_v) begin
            $display("FAIL redirect_bubble: got %h expected %h", obs, exp_v);
            n_fail++;
        end
        step();
        n_tests++;
        exp_v = {1'b1, 1'b0, 8'h10, 8'h12, 16'd16};
        if (obs !== exp_v || ir !== 16'hF009) begin
            $display("FAIL redirect_target: got %h/%h expected %h/F009", obs, ir, exp_v);
            n_fail++;
        end
    endtask

    task automatic test_halt();
        repeat (19) step();
        n_tests++;
        exp_v = {1'b1, 1'b0, 8'h36, 8'h38, 16'd35};
        if (obs !== exp_v) begin
            $display("FAIL pre_halt: got %h expected %h", obs, exp_v);
            n_fail++;
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            exp_v = {1'b0, 1'b1, 8'h36, 8'h38, 16'd36};
            if (obs !== exp_v || ir !== 16'hF01C) begin
                $display("FAIL halted%0d: got %h/%h expected %h/F01C", k, obs, ir, exp_v);
                n_fail++;
            end
        end
        redirect    = 1'b1;
        redirect_pc = 8'h10;
        step();
        redirect = 1'b0;
        n_tests++;
        exp_v = {1'b0, 1'b0, 8'h36, 8'h10, 16'd36};
        if (obs !== exp_v) begin
            $display("FAIL halt_exit: got %h expected %h", obs, exp_v);
            n_fail++;
        end
        step();
        n_tests++;
        exp_v = {1'b1, 1'b0, 8'h10, 8'h12, 16'd36};
        if (obs !== exp_v) begin
            $display("FAIL halt_resume: got %h expected %h", obs, exp_v);
            n_fail++;
        end
    endtask

    task automatic test_halt_redirect();
        redirect    = 1'b1;
        redirect_pc = 8'h38;
        step();
        n_tests++;
        exp_v = {1'b0, 1'b0, 8'h10, 8'h38, 16'd37};
        if (obs !== exp_v) begin
            $display("FAIL to_halt_word: got %h expected %h", obs, exp_v);
            n_fail++;
        end
        redirect_pc = 8'h20;
        step();
        redirect = 1'b0;
        n_tests++;
        exp_v = {1'b0, 1'b0, 8'h10, 8'h20, 16'd37};
        if (obs !== exp_v) begin
            $display("FAIL redirect_beats_halt: got %h expected %h", obs, exp_v);
            n_fail++;
        end
        step();
        n_tests++;
        exp_v = {1'b1, 1'b0, 8'h20, 8'h22, 16'd37};
        if (obs !== exp_v || ir !== 16'hF011) begin
            $display("FAIL post_race_fetch: got %h/%h expected %h/F011", obs, ir, exp_v);
            n_fail++;
        end
    endtask

    task automatic test_wrap();
        redirect    = 1'b1;
        redirect_pc = 8'hFE;
        step();
        redirect = 1'b0;
        n_tests++;
        exp_v = {1'b0, 1'b0, 8'h20, 8'hFE, 16'd38};
        if (obs !== exp_v) begin
            $display("FAIL wrap_redirect: got %h expected %h", obs, exp_v);
            n_fail++;
        end
        step();
        n_tests++;
        exp_v = {1'b1, 1'b0, 8'hFE, 8'h00, 16'd38};
        if (obs !== exp_v || ir !== 16'hF080) begin
            $display("FAIL wrap_pc: got %h/%h expected %h/F080", obs, ir, exp_v);
            n_fail++;
        end
        step();
        n_tests++;
        exp_v = {1'b1, 1'b0, 8'h00, 8'h02, 16'd39};
        if (obs !== exp_v) begin
            $display("FAIL wrap_next: got %h expected %h", obs, exp_v);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        exp_v = {1'b0, 1'b0, 8'h00, 8'h00, 16'd0};
        if (obs !== exp_v || ir !== 16'h0000) begin
            $display("FAIL async_reset: got %h/%h expected %h/0000", obs, ir, exp_v);
            n_fail++;
        end
        step();
        rst_n = 1'b1;
        step();
        n_tests++;
        if (obs !== exp_v) begin
            $display("FAIL reboot_cycle: got %h expected %h", obs, exp_v);
            n_fail++;
        end
        step();
        n_tests++;
        exp_v = {1'b1, 1'b0, 8'h00, 8'h02, 16'd0};
        if (obs !== exp_v || ir !== 16'hF001) begin
            $display("FAIL reboot_first: got %h/%h expected %h/F001", obs, ir, exp_v);
            n_fail++;
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        dec_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        for (int i = 0; i < 128; i++) begin
            rom[i] = 16'hF001 + 16'(i);
        end
        rom[8'h1C] = 16'h0000;

        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_halt();
        test_halt_redirect();
        test_wrap();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
